// File: rtl/bram_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_fifo_pkg
//  Description : Shared constants and helpers for the BRAM-backed FIFO slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_fifo_pkg;

    localparam int LAT_HP = 2;
    localparam int LAT_LL = 1;

    function automatic int fifo_lat(input string perf);
        return (perf == "LOW_LATENCY") ? LAT_LL : LAT_HP;
    endfunction

    // Bits needed to address 'value' items; never returns less than 1.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_fifo_skid.sv
`default_nettype none
// ============================================================================
//  Module      : bram_fifo_skid
//  Description : Small circular prefetch buffer feeding the FIFO output.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_fifo_skid
    import bram_fifo_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SKID  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [clogb2(SKID+1)-1:0]  cnt
);
    localparam int c_IW = clogb2(SKID);
    localparam int c_CW = clogb2(SKID + 1);

    logic [WIDTH-1:0] r_buf [SKID];
    logic [c_IW-1:0]  r_wr_idx;
    logic [c_IW-1:0]  r_rd_idx;
    logic [c_CW-1:0]  r_cnt;

    function automatic logic [c_IW-1:0] idx_next(input logic [c_IW-1:0] idx);
        return (idx == c_IW'(SKID - 1)) ? '0 : idx + c_IW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) r_buf[r_wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_cnt    <= '0;
        end else if (flush) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_cnt    <= '0;
        end else begin
            if (wr_en) r_wr_idx <= idx_next(r_wr_idx);
            if (rd_en) r_rd_idx <= idx_next(r_rd_idx);
            r_cnt <= r_cnt + c_CW'(wr_en) - c_CW'(rd_en);
        end
    end

    assign out_valid = (r_cnt != '0);
    assign out_data  = r_buf[r_rd_idx];
    assign cnt       = r_cnt;

endmodule
`default_nettype wire

// File: rtl/xilinx_simple_dual_port_1_clock_ram.sv
`default_nettype none
// ============================================================================
//  Module      : xilinx_simple_dual_port_1_clock_ram
//  Description : Single-clock simple dual-port block RAM, optional output reg.
//  Revision    : 1.0 - initial release
// ============================================================================
module xilinx_simple_dual_port_1_clock_ram
    import bram_fifo_pkg::*;
#(
    parameter int    RAM_WIDTH       = 64,
    parameter int    RAM_DEPTH       = 512,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [clogb2(RAM_DEPTH)-1:0] addra,
    input  logic [clogb2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         enb,
    input  logic                         rstb,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         doutb
);
    logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] r_ram_data;

    always_ff @(posedge clka) begin
        if (wea) r_mem[addra] <= dina;
        if (enb) r_ram_data <= r_mem[addrb];
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
            logic w_unused_ctrl;
            assign w_unused_ctrl = rstb ^ regceb;
            assign doutb         = r_ram_data;
        end else begin : g_out_reg
            logic [RAM_WIDTH-1:0] r_doutb;
            always_ff @(posedge clka) begin
                if (rstb)        r_doutb <= '0;
                else if (regceb) r_doutb <= r_ram_data;
            end
            assign doutb = r_doutb;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bram_sdp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bram_sdp_fifo_ctrl
//  Description : Valid/ready FIFO on a simple dual-port BRAM with prefetch skid.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_sdp_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int    WIDTH       = 64,
    parameter int    DEPTH       = 512,
    parameter string PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           flush,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [WIDTH-1:0]                               in_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [WIDTH-1:0]                               out_data,
    output logic [clogb2(DEPTH+fifo_lat(PERFORMANCE)+2)-1:0] level,
    output logic                                           empty
);
    localparam int c_LAT  = fifo_lat(PERFORMANCE);
    localparam int c_SKID = c_LAT + 1;
    localparam int c_AW   = clogb2(DEPTH);
    localparam int c_CW   = clogb2(DEPTH + 1);
    localparam int c_SW   = clogb2(c_SKID + 1);
    localparam int c_LW   = clogb2(DEPTH + c_SKID + 1);

    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_ram_cnt;
    logic [c_LAT-1:0] r_flags;
    logic [c_LW-1:0]  r_level;
    logic             r_run;

    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic             w_capture;
    logic [c_SW-1:0]  w_skid_cnt;
    logic [c_SW-1:0]  w_inflight_cnt;
    logic [c_SW:0]    w_used;
    logic [c_SW:0]    w_limit;
    logic [WIDTH-1:0] w_ram_dout;

    assign in_ready = r_run & (r_ram_cnt != c_CW'(DEPTH)) & ~flush;
    assign w_push   = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < c_LAT; i++) begin
            w_inflight_cnt = w_inflight_cnt + c_SW'(r_flags[i]);
        end
    end

    // The head leaving this cycle frees its slot, which keeps one issue per cycle when streaming.
    assign w_used    = {1'b0, w_skid_cnt} + {1'b0, w_inflight_cnt};
    assign w_limit   = (c_SW+1)'(c_SKID) + (c_SW+1)'(w_pop);
    assign w_issue   = (r_ram_cnt != '0) & (w_used < w_limit) & ~flush;
    assign w_capture = r_flags[c_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run     <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
            r_flags   <= '0;
            r_level   <= '0;
        end else begin
            r_run <= 1'b1;
            if (flush) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_ram_cnt <= '0;
                r_flags   <= '0;
                r_level   <= '0;
            end else begin
                if (w_push)  r_wr_ptr <= r_wr_ptr + c_AW'(1);
                if (w_issue) r_rd_ptr <= r_rd_ptr + c_AW'(1);
                r_ram_cnt <= r_ram_cnt + c_CW'(w_push) - c_CW'(w_issue);
                r_flags   <= (r_flags << 1) | c_LAT'(w_issue);
                // Issue and capture only move words between internal stages.
                r_level   <= r_level + c_LW'(w_push) - c_LW'(w_pop);
            end
        end
    end

    xilinx_simple_dual_port_1_clock_ram #(
        .RAM_WIDTH       (WIDTH),
        .RAM_DEPTH       (DEPTH),
        .RAM_PERFORMANCE (PERFORMANCE)
    ) u_ram (
        .addra  (r_wr_ptr),
        .addrb  (r_rd_ptr),
        .dina   (in_data),
        .clka   (clk),
        .wea    (w_push),
        .enb    (w_issue),
        .rstb   (1'b0),
        .regceb (1'b1),
        .doutb  (w_ram_dout)
    );

    bram_fifo_skid #(
        .WIDTH (WIDTH),
        .SKID  (c_SKID)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .wr_en     (w_capture),
        .wr_data   (w_ram_dout),
        .rd_en     (w_pop),
        .out_valid (out_valid),
        .out_data  (out_data),
        .cnt       (w_skid_cnt)
    );

    assign level = r_level;
    assign empty = (r_level == '0);

endmodule
`default_nettype wire

// File: tb/tb_bram_sdp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_sdp_fifo_ctrl
//  Description : Scoreboard bench driving HIGH_PERFORMANCE and LOW_LATENCY FIFOs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_sdp_fifo_ctrl;
    localparam int W     = 32;
    localparam int DEPTH = 512;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         flush     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data   = '0;

    logic         in_ready  [2];
    logic         out_valid [2];
    logic         empty     [2];
    logic [W-1:0] out_data  [2];
    logic [9:0]   level     [2];

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           push_cnt [2];
    int           pop_cnt  [2];
    int           first_pop[2];
    int           last_pop [2];
    logic [W-1:0] sb_q     [2][$];
    logic [W-1:0] mon_exp;

    always #5 clk = ~clk;

    bram_sdp_fifo_ctrl #(.WIDTH(W), .DEPTH(DEPTH), .PERFORMANCE("HIGH_PERFORMANCE")) u_hp (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .level(level[0]), .empty(empty[0])
    );

    bram_sdp_fifo_ctrl #(.WIDTH(W), .DEPTH(DEPTH), .PERFORMANCE("LOW_LATENCY")) u_ll (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .level(level[1]), .empty(empty[1])
    );

    task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Monitor: handshakes decided now take effect at the next posedge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) sb_q[d].delete();
        end else begin
            for (int d = 0; d < 2; d++) begin
                check("level", d, 64'(level[d]), 64'(sb_q[d].size()));
                check("empty", d, 64'(empty[d]), 64'(sb_q[d].size() == 0));
                if (out_valid[d] && out_ready) begin
                    checks++;
                    if (sb_q[d].size() == 0) begin
                        failures++;
                        $display("FAIL spurious_out dut%0d: got 0x%0h expected no word at %0t", d, out_data[d], $time);
                    end else begin
                        mon_exp = sb_q[d].pop_front();
                        checks--;
                        check("out_data", d, 64'(out_data[d]), 64'(mon_exp));
                    end
                    pop_cnt[d]++;
                    if (first_pop[d] < 0) first_pop[d] = cyc;
                    last_pop[d] = cyc;
                end
                if (in_valid && in_ready[d]) begin
                    sb_q[d].push_back(in_data);
                    push_cnt[d]++;
                end
                if (flush) sb_q[d].delete();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            push_cnt[d]  = 0;
            pop_cnt[d]   = 0;
            first_pop[d] = -1;
            last_pop[d]  = -1;
        end
    endtask

    task automatic drain(input string name, input int maxc);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (!(empty[0] && empty[1]) && n < maxc) begin
            step();
            n++;
        end
        check({name, "_drained"}, 0, 64'(empty[0] && empty[1]), 64'd1);
    endtask

    // After a flush or reset the first word out of each FIFO must be 0x1.
    task automatic first_word_is_one(input string name);
        logic seen [2];
        int   n;
        seen[0] = 1'b0;
        seen[1] = 1'b0;
        n       = 0;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (!(seen[0] && seen[1]) && n < 10) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (out_valid[d] && !seen[d]) begin
                    check({name, "_first_word"}, d, 64'(out_data[d]), 64'h1);
                    seen[d] = 1'b1;
                end
            end
            n++;
        end
        for (int d = 0; d < 2; d++) check({name, "_first_seen"}, d, 64'(seen[d]), 64'd1);
        step();
    endtask

    initial begin
        int i;
        clear_counts();
        #2 rst_n = 1'b0;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", d, 64'(in_ready[d]), 64'd0);
            check("rst_out_valid", d, 64'(out_valid[d]), 64'd0);
            check("rst_level", d, 64'(level[d]), 64'd0);
            check("rst_empty", d, 64'(empty[d]), 64'd1);
        end
        rst_n = 1'b1;
        step();
        for (int d = 0; d < 2; d++) check("post_rst_in_ready", d, 64'(in_ready[d]), 64'd1);

        // Single word: out_valid after 3 edges (HP) / 2 edges (LL).
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA5;
        step();
        in_valid  = 1'b0;
        @(negedge clk);
        check("lat_e0", 0, 64'(out_valid[0]), 64'd0);
        check("lat_e0", 1, 64'(out_valid[1]), 64'd0);
        @(negedge clk);
        check("lat_e1", 0, 64'(out_valid[0]), 64'd0);
        check("lat_e1", 1, 64'(out_valid[1]), 64'd0);
        @(negedge clk);
        check("lat_e2", 0, 64'(out_valid[0]), 64'd0);
        check("lat_e2", 1, 64'(out_valid[1]), 64'd1);
        check("lat_e2_data", 1, 64'(out_data[1]), 64'hA5);
        @(negedge clk);
        check("lat_e3", 0, 64'(out_valid[0]), 64'd1);
        check("lat_e3_data", 0, 64'(out_data[0]), 64'hA5);
        check("lat_e3_level", 0, 64'(level[0]), 64'd1);
        check("lat_e3", 1, 64'(out_valid[1]), 64'd0);
        @(negedge clk);
        check("lat_e4_level", 0, 64'(level[0]), 64'd0);
        step();

        // Streaming 2048 words, no bubbles once the first word appears.
        clear_counts();
        out_ready = 1'b1;
        for (int k = 0; k < 2048; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h1000_0000 + k;
            step();
        end
        drain("stream", 50);
        for (int d = 0; d < 2; d++) begin
            check("stream_pops", d, 64'(pop_cnt[d]), 64'd2048);
            check("stream_span", d, 64'(last_pop[d] - first_pop[d]), 64'd2047);
        end

        // Fill with the consumer stalled, then drain in order.
        clear_counts();
        out_ready = 1'b0;
        i = 0;
        while ((in_ready[0] || in_ready[1]) && i < 700) begin
            in_valid = 1'b1;
            in_data  = 32'h2000_0000 + i;
            step();
            i++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("full_level", 0, 64'(level[0]), 64'd515);
        check("full_level", 1, 64'(level[1]), 64'd514);
        check("full_in_ready", 0, 64'(in_ready[0]), 64'd0);
        step();
        drain("fill", 600);
        check("fill_pops", 0, 64'(pop_cnt[0]), 64'd515);

        // Random valid/ready traffic.
        for (int k = 0; k < 6000; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            step();
        end
        drain("random", 600);

        // Pointer wrap at roughly half occupancy.
        clear_counts();
        out_ready = 1'b0;
        for (int k = 0; k < 256; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h3000_0000 + k;
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h3100_0000 + k;
            step();
        end
        drain("wrap", 600);
        for (int d = 0; d < 2; d++) check("wrap_pushes", d, 64'(push_cnt[d]), 64'(256 + 3 * DEPTH));

        // Flush with reads in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h4000_0000 + k;
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("flush_level", d, 64'(level[d]), 64'd0);
            check("flush_out_valid", d, 64'(out_valid[d]), 64'd0);
        end
        first_word_is_one("flush");
        drain("flush", 20);

        // Reset in the middle of a stream.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h5000_0000 + k;
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("midrst_level", d, 64'(level[d]), 64'd0);
            check("midrst_out_valid", d, 64'(out_valid[d]), 64'd0);
            check("midrst_in_ready", d, 64'(in_ready[d]), 64'd0);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        first_word_is_one("midrst");
        drain("midrst", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
